// File: rtl/alu_operand_regfile.sv
// Operand/writeback stage around the 8-bit ALU: register file with R0 tied
// to zero, write-through bypass on both read ports, B-operand source mux,
// and the registered carry/zero status flags.
module alu_operand_regfile #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic [1:0]        b_sel,
  input  logic [DATA_W-1:0] imm,
  input  logic [2:0]        shamt,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] alu_r,
  input  logic              flag_we,
  input  logic              alu_zero,
  input  logic              alu_carry,
  output logic              carry_flag,
  output logic              zero_flag
);

  typedef enum logic [1:0] {
    B_REG  = 2'b00,
    B_IMM  = 2'b01,
    B_SHFT = 2'b10,
    B_REG2 = 2'b11
  } b_src_e;

  logic [DATA_W-1:0] regs [NREGS];
  logic              wr_live;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  b_src_e            b_src;

  // A write to R0 is a no-op everywhere, so it neither bypasses nor stores.
  assign wr_live = wr_en && (rd_addr != '0);
  assign b_src   = b_src_e'(b_sel);

  // Register storage; reset clears everything and drops any write on that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_live) begin
      regs[rd_addr] <= alu_r;
    end
  end

  // Status flags; no bypass so carry_flag never loops back through the ALU combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_flag <= 1'b0;
      zero_flag  <= 1'b0;
    end else if (flag_we) begin
      carry_flag <= alu_carry;
      zero_flag  <= alu_zero;
    end
  end

  // Combinational read ports with R0 forced to zero and write-through bypass.
  always_comb begin
    rs_val = '0;
    rt_val = '0;
    if (rs_addr != '0) begin
      rs_val = (wr_live && (rd_addr == rs_addr)) ? alu_r : regs[rs_addr];
    end
    if (rt_addr != '0) begin
      rt_val = (wr_live && (rd_addr == rt_addr)) ? alu_r : regs[rt_addr];
    end
  end

  // Operand A is always rs; operand B picks register, immediate or zero-extended shift amount.
  always_comb begin
    op_a = rs_val;
    op_b = rt_val;
    case (b_src)
      B_IMM:   op_b = imm;
      B_SHFT:  op_b = {{(DATA_W-3){1'b0}}, shamt};
      default: op_b = rt_val;
    endcase
  end

endmodule
